// File: rtl/bp_pkg.sv
// Shared types for the fetch-side branch predictor: counter encodings, BTB entry
// layout and the PC -> index/tag split.
package bp_pkg;

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } ctr_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [31:2]       target;
    ctr_t              ctr;
  } bp_entry_t;

  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[IDX_W+2 +: TAG_W];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Prediction (IF) and resolution (EX/MEM) signals between the pipeline and the predictor.
interface bp_if;
  logic [31:0] IF_PC;
  logic        IF_PredTaken;
  logic [31:0] IF_PredTarget;
  logic        EM_Update;
  logic [31:0] EM_BranchPC;
  logic        EM_ActualTaken;
  logic [31:0] EM_ActualTarget;
  logic        EM_PredTaken;

  modport slave (
    input  IF_PC, EM_Update, EM_BranchPC, EM_ActualTaken, EM_ActualTarget, EM_PredTaken,
    output IF_PredTaken, IF_PredTarget
  );

  modport master (
    output IF_PC, EM_Update, EM_BranchPC, EM_ActualTaken, EM_ActualTarget, EM_PredTaken,
    input  IF_PredTaken, IF_PredTarget
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: up on taken, down on not-taken, clamped at SN/ST.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      SN: ctr_o = taken_i ? WN : SN;
      WN: ctr_o = taken_i ? WT : SN;
      WT: ctr_o = taken_i ? ST : WN;
      ST: ctr_o = taken_i ? ST : WT;
      default: ctr_o = WN;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, one-cycle training write.
// Optional resolved/mispredict statistics are built only when BP_STATS_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = IDX_W,
  parameter int unsigned TAG_BITS = TAG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  bp_if.slave         bus,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int unsigned N_ENTRIES = 1 << IDX_BITS;

  bp_entry_t table_q [N_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  bp_entry_t        lk_entry;
  logic             lk_taken;

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_idx   = pc_idx(bus.IF_PC);
    lk_tag   = pc_tag(bus.IF_PC);
    lk_entry = table_q[lk_idx];
    lk_taken = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
  end

  assign bus.IF_PredTaken  = lk_taken;
  assign bus.IF_PredTarget = lk_taken ? {lk_entry.target, 2'b00} : bus.IF_PC + 32'd4;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  bp_entry_t        up_entry;
  logic             up_hit;
  ctr_t             up_ctr_next;

  always_comb begin
    up_idx   = pc_idx(bus.EM_BranchPC);
    up_tag   = pc_tag(bus.EM_BranchPC);
    up_entry = table_q[up_idx];
    up_hit   = up_entry.valid && (up_entry.tag == up_tag);
  end

  bp_sat_counter u_ctr (
    .ctr_i   (up_entry.ctr),
    .taken_i (bus.EM_ActualTaken),
    .ctr_o   (up_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WN};
      end
    end else if (bus.EM_Update) begin
      if (up_hit) begin
        table_q[up_idx].ctr <= up_ctr_next;
        if (bus.EM_ActualTaken) begin
          table_q[up_idx].target <= bus.EM_ActualTarget[31:2];
        end
      end else if (bus.EM_ActualTaken) begin
        table_q[up_idx] <= '{valid: 1'b1, tag: up_tag,
                             target: bus.EM_ActualTarget[31:2], ctr: WT};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q,  stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (bus.EM_Update) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (bus.EM_PredTaken != bus.EM_ActualTaken) begin
        stat_mispred_d = stat_mispred_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

  logic unused_bits;
  assign unused_bits = ^{bus.EM_BranchPC[1:0], bus.EM_ActualTarget[1:0]};
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;

  logic unused_bits;
  assign unused_bits = ^{bus.EM_BranchPC[1:0], bus.EM_ActualTarget[1:0], bus.EM_PredTaken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build and BP_STATS_EN build).
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk;
  logic rst_n;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int checks;
  int errors;

  bp_if bus();

  branch_predictor #(.IDX_BITS(4), .TAG_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic pred);
    @(negedge clk);
    bus.EM_Update       = 1'b1;
    bus.EM_BranchPC     = pc;
    bus.EM_ActualTaken  = taken;
    bus.EM_ActualTarget = target;
    bus.EM_PredTaken    = pred;
    @(posedge clk);
    #1;
    bus.EM_Update = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.IF_PC = 32'h0040_0010;
    bus.EM_Update = 1'b0;
    bus.EM_BranchPC = '0;
    bus.EM_ActualTaken = 1'b0;
    bus.EM_ActualTarget = '0;
    bus.EM_PredTaken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b0) begin
      errors++; $display("FAIL reset_pred: got %b exp 0", bus.IF_PredTaken);
    end
    checks++;
    if (bus.IF_PredTarget !== 32'h0040_0014) begin
      errors++; $display("FAIL reset_target: got %h exp 00400014", bus.IF_PredTarget);
    end
    checks++;
    if (dut.table_q[4].ctr !== 2'b01) begin
      errors++; $display("FAIL reset_ctr: got %b exp 01", dut.table_q[4].ctr);
    end
    checks++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", stat_branches, stat_mispred);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_train;
    do_update(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0);
    bus.IF_PC = 32'h0040_0010;
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b1) begin
      errors++; $display("FAIL train_pred: got %b exp 1", bus.IF_PredTaken);
    end
    checks++;
    if (bus.IF_PredTarget !== 32'h0040_0040) begin
      errors++; $display("FAIL train_target: got %h exp 00400040", bus.IF_PredTarget);
    end
    checks++;
    if (dut.table_q[4].ctr !== 2'b10) begin
      errors++; $display("FAIL train_ctr: got %b exp 10", dut.table_q[4].ctr);
    end
  endtask

  task automatic test_saturation;
    repeat (3) do_update(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1);
    checks++;
    if (dut.table_q[4].ctr !== 2'b11) begin
      errors++; $display("FAIL sat_ctr_st: got %b exp 11", dut.table_q[4].ctr);
    end
    do_update(32'h0040_0010, 1'b0, 32'h0040_0014, 1'b1);
    checks++;
    if (dut.table_q[4].ctr !== 2'b10 || bus.IF_PredTaken !== 1'b1
        || bus.IF_PredTarget !== 32'h0040_0040) begin
      errors++; $display("FAIL sat_wt: got ctr=%b pred=%b tgt=%h exp 10/1/00400040",
                         dut.table_q[4].ctr, bus.IF_PredTaken, bus.IF_PredTarget);
    end
    do_update(32'h0040_0010, 1'b0, 32'h0040_0014, 1'b1);
    checks++;
    if (dut.table_q[4].ctr !== 2'b01 || bus.IF_PredTaken !== 1'b0
        || bus.IF_PredTarget !== 32'h0040_0014) begin
      errors++; $display("FAIL sat_wn: got ctr=%b pred=%b tgt=%h exp 01/0/00400014",
                         dut.table_q[4].ctr, bus.IF_PredTaken, bus.IF_PredTarget);
    end
    repeat (2) do_update(32'h0040_0010, 1'b0, 32'h0040_0014, 1'b0);
    checks++;
    if (dut.table_q[4].ctr !== 2'b00) begin
      errors++; $display("FAIL sat_sn: got %b exp 00", dut.table_q[4].ctr);
    end
  endtask

  task automatic test_alias;
    do_update(32'h0040_1010, 1'b1, 32'h0040_1100, 1'b0);
    bus.IF_PC = 32'h0040_0010;
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b0 || bus.IF_PredTarget !== 32'h0040_0014) begin
      errors++; $display("FAIL alias_old: got %b/%h exp 0/00400014",
                         bus.IF_PredTaken, bus.IF_PredTarget);
    end
    bus.IF_PC = 32'h0040_1010;
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b1 || bus.IF_PredTarget !== 32'h0040_1100) begin
      errors++; $display("FAIL alias_new: got %b/%h exp 1/00401100",
                         bus.IF_PredTaken, bus.IF_PredTarget);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    bus.IF_PC           = 32'h0040_1010;
    bus.EM_Update       = 1'b1;
    bus.EM_BranchPC     = 32'h0040_1010;
    bus.EM_ActualTaken  = 1'b0;
    bus.EM_ActualTarget = 32'h0040_1014;
    bus.EM_PredTaken    = 1'b1;
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b1 || bus.IF_PredTarget !== 32'h0040_1100) begin
      errors++; $display("FAIL same_cycle_old: got %b/%h exp 1/00401100",
                         bus.IF_PredTaken, bus.IF_PredTarget);
    end
    @(posedge clk);
    #1;
    bus.EM_Update = 1'b0;
    checks++;
    if (bus.IF_PredTaken !== 1'b0 || bus.IF_PredTarget !== 32'h0040_1014) begin
      errors++; $display("FAIL same_cycle_new: got %b/%h exp 0/00401014",
                         bus.IF_PredTaken, bus.IF_PredTarget);
    end
    do_update(32'h0040_0020, 1'b0, 32'h0040_0024, 1'b0);
    bus.IF_PC = 32'h0040_0020;
    #1;
    checks++;
    if (dut.table_q[8].valid !== 1'b0 || bus.IF_PredTaken !== 1'b0) begin
      errors++; $display("FAIL nt_miss_noalloc: got valid=%b pred=%b exp 0/0",
                         dut.table_q[8].valid, bus.IF_PredTaken);
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    bus.EM_Update       = 1'b0;
    bus.EM_BranchPC     = 32'h0040_0030;
    bus.EM_ActualTaken  = 1'b1;
    bus.EM_ActualTarget = 32'h0040_0200;
    bus.EM_PredTaken    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.IF_PC = 32'h0040_0030;
    #1;
    checks++;
    if (dut.table_q[12].valid !== 1'b0 || bus.IF_PredTaken !== 1'b0) begin
      errors++; $display("FAIL hold_no_update: got valid=%b pred=%b exp 0/0",
                         dut.table_q[12].valid, bus.IF_PredTaken);
    end
  endtask

  task automatic test_stats;
    logic [31:0] exp_b;
    logic [31:0] exp_m;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic mis;
      mis = (i == 1) || (i == 4) || (i == 7);
      do_update(32'h0040_0100, 1'b1, 32'h0040_0300, mis ? 1'b0 : 1'b1);
    end
`ifdef BP_STATS_EN
    exp_b = 32'd10;
    exp_m = 32'd3;
`else
    exp_b = 32'd0;
    exp_m = 32'd0;
`endif
    checks++;
    if (stat_branches !== exp_b) begin
      errors++; $display("FAIL stat_branches: got %0d exp %0d", stat_branches, exp_b);
    end
    checks++;
    if (stat_mispred !== exp_m) begin
      errors++; $display("FAIL stat_mispred: got %0d exp %0d", stat_mispred, exp_m);
    end
`ifdef BP_STATS_EN
    @(negedge clk);
    dut.stat_branches_q = 32'hFFFF_FFFF;
    do_update(32'h0040_0100, 1'b1, 32'h0040_0300, 1'b1);
    checks++;
    if (stat_branches !== 32'd0) begin
      errors++; $display("FAIL stat_wrap: got %h exp 00000000", stat_branches);
    end
`endif
    bus.IF_PC = 32'h0040_0100;
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b1) begin
      errors++; $display("FAIL pre_pulse_pred: got %b exp 1", bus.IF_PredTaken);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.IF_PredTaken !== 1'b0 || bus.IF_PredTarget !== 32'h0040_0104
        || stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL async_pulse: got %b/%h/%0d/%0d exp 0/00400104/0/0",
                         bus.IF_PredTaken, bus.IF_PredTarget, stat_branches, stat_mispred);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_update;
    @(negedge clk);
    bus.EM_Update       = 1'b1;
    bus.EM_BranchPC     = 32'h0040_0030;
    bus.EM_ActualTaken  = 1'b1;
    bus.EM_ActualTarget = 32'h0040_0200;
    bus.EM_PredTaken    = 1'b0;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.IF_PC = 32'h0040_0030;
    #1;
    checks++;
    if (dut.table_q[12].valid !== 1'b0 || bus.IF_PredTaken !== 1'b0
        || stat_branches !== 32'd0) begin
      errors++; $display("FAIL reset_mid_update: got valid=%b pred=%b br=%0d exp 0/0/0",
                         dut.table_q[12].valid, bus.IF_PredTaken, stat_branches);
    end
    @(negedge clk);
    bus.EM_Update = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_train();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_hold();
    test_stats();
    test_reset_mid_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
